// File: rtl/bin_bcd_dabble.sv
// ---------------------------------------------------------------------------
// bin_bcd_dabble : sequential binary -> packed BCD converter (double dabble)
//
// One double-dabble iteration per clock. A conversion accepted at edge k
// registers its results at edge k+BIN_W, and done is high for the one cycle
// after that edge. The next conversion can be accepted BIN_W+2 edges after k.
//
// Parameters
//   BIN_W     : operand width (4..32)
//   DIGITS    : number of BCD result digits (1..10)
//   SIGNED_EN : 1 = operand is two's complement, converted as sign + magnitude
// Ports
//   Sys_CLK   : system clock, rising edge
//   Sys_RST_N : asynchronous active-low reset
//   start     : conversion request, only looked at while idle
//   data_bin  : operand, captured on the accepting edge
//   busy      : high from the accepting edge until the FSM is idle again
//   done      : one-cycle pulse, results valid
//   data_bcd  : packed 8421 BCD, least-significant digit in [3:0]
//   sign      : result is negative (always 0 when SIGNED_EN=0)
//   ovf       : magnitude needs more than DIGITS digits; data_bcd shows all 9s
//   ndig      : number of significant digits (1 for a zero result)
// ---------------------------------------------------------------------------

// Per-digit add-3 correction applied before each shift.
module bcd_dig_adj (
    input  logic [3:0] dig_i,
    output logic [3:0] dig_o
);
    always_comb dig_o = (dig_i >= 4'd5) ? dig_i + 4'd3 : dig_i;
endmodule

module bin_bcd_dabble #(
    parameter int BIN_W     = 20,
    parameter int DIGITS    = 7,
    parameter int SIGNED_EN = 0
) (
    input  logic                           Sys_CLK,
    input  logic                           Sys_RST_N,
    input  logic                           start,
    input  logic [BIN_W-1:0]               data_bin,
    output logic                           busy,
    output logic                           done,
    output logic [4*DIGITS-1:0]            data_bcd,
    output logic                           sign,
    output logic                           ovf,
    output logic [$clog2(DIGITS+1)-1:0]    ndig
);
    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam int NW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [DW-1:0]    dig_q, dig_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_int_q, ovf_int_d;
    logic             sign_int_q, sign_int_d;
    logic [DW-1:0]    bcd_q, bcd_d;
    logic             sign_q, sign_d;
    logic             ovf_q, ovf_d;
    logic [NW-1:0]    ndig_q, ndig_d;

    // One iteration: correct every digit, then shift {digits, operand} left.
    logic [DW-1:0]    dig_adj;
    logic [DW-1:0]    dig_sh;
    logic [BIN_W-1:0] bin_sh;
    logic             carry;
    logic             ovf_nx;
    logic [NW-1:0]    ndig_sh;
    logic             neg;
    logic [BIN_W-1:0] mag;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_dig_adj u_adj (
            .dig_i (dig_q[4*g +: 4]),
            .dig_o (dig_adj[4*g +: 4])
        );
    end

    // A corrected top digit >= 8 carries out on the shift, which is exactly
    // the case where the running value no longer fits in DIGITS digits.
    assign carry  = dig_adj[DW-1];
    assign dig_sh = {dig_adj[DW-2:0], bin_q[BIN_W-1]};
    assign bin_sh = {bin_q[BIN_W-2:0], 1'b0};
    assign ovf_nx = ovf_int_q | carry;

    always_comb begin
        ndig_sh = NW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_sh[4*i +: 4] != 4'd0) ndig_sh = NW'(i + 1);
        end
    end

    assign neg = (SIGNED_EN != 0) && data_bin[BIN_W-1];
    assign mag = neg ? (~data_bin + BIN_W'(1)) : data_bin;

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        dig_d      = dig_q;
        cnt_d      = cnt_q;
        ovf_int_d  = ovf_int_q;
        sign_int_d = sign_int_q;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        ovf_d      = ovf_q;
        ndig_d     = ndig_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d      = mag;
                    sign_int_d = neg;
                    dig_d      = '0;
                    ovf_int_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                dig_d     = dig_sh;
                bin_d     = bin_sh;
                ovf_int_d = ovf_nx;
                cnt_d     = cnt_q + CW'(1);
                // Last iteration: publish the post-shift value on this edge.
                if (cnt_q == CW'(BIN_W - 1)) begin
                    state_d = S_DONE;
                    bcd_d   = ovf_nx ? {DIGITS{4'h9}} : dig_sh;
                    ovf_d   = ovf_nx;
                    sign_d  = sign_int_q;
                    ndig_d  = ovf_nx ? NW'(DIGITS) : ndig_sh;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
        if (!Sys_RST_N) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            dig_q      <= '0;
            cnt_q      <= '0;
            ovf_int_q  <= 1'b0;
            sign_int_q <= 1'b0;
            bcd_q      <= '0;
            sign_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ndig_q     <= NW'(1);
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            dig_q      <= dig_d;
            cnt_q      <= cnt_d;
            ovf_int_q  <= ovf_int_d;
            sign_int_q <= sign_int_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            ovf_q      <= ovf_d;
            ndig_q     <= ndig_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign data_bcd = bcd_q;
    assign sign     = sign_q;
    assign ovf      = ovf_q;
    assign ndig     = ndig_q;

endmodule

// File: doc/bin_bcd_dabble.md
BIN_BCD_DABBLE -- requirements
Module: bin_bcd_dabble

Interface
REQ-001 The block SHALL have parameter BIN_W, default 20, binary operand width, legal range 4..32.
REQ-002 The block SHALL have parameter DIGITS, default 7, number of BCD output digits, legal range 1..10.
REQ-003 The block SHALL have parameter SIGNED_EN, default 0; 1 means the operand is two's complement.
REQ-004 The block SHALL have port Sys_CLK, input, 1, the single system clock; all logic is rising-edge.
REQ-005 The block SHALL have port Sys_RST_N, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1, conversion request, sampled only in IDLE.
REQ-007 The block SHALL have port data_bin, input, BIN_W, operand, captured at the accepting edge.
REQ-008 The block SHALL have port busy, output, 1, high while state is not IDLE.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-010 The block SHALL have port data_bcd, output, 4*DIGITS, packed 8421 BCD result with the least-significant digit in [3:0].
REQ-011 The block SHALL have port sign, output, 1, result negative; tied 0 when SIGNED_EN=0.
REQ-012 The block SHALL have port ovf, output, 1, magnitude not representable in DIGITS digits.
REQ-013 The block SHALL have port ndig, output, clog2(DIGITS+1), count of significant digits.

Function
REQ-014 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-015 In IDLE with start=1, the block SHALL capture the operand, clear the digit register, ovf_int and the iteration counter, and go to SHIFT on the same edge.
REQ-016 When SIGNED_EN=1 and data_bin[BIN_W-1]=1, the captured magnitude SHALL be the BIN_W-bit two's-complement negation and sign_int SHALL be 1; otherwise the magnitude is data_bin and sign_int is 0.
REQ-017 In SHIFT, each edge SHALL perform exactly one double-dabble iteration: every digit >=5 gets +3, then {digits, operand} shifts left 1 bit.
REQ-018 During any SHIFT iteration, if the bit shifted out of the top digit is 1, ovf_int SHALL be set and SHALL stay set until the next capture.
REQ-019 After BIN_W iterations, the block SHALL move to DONE and on that same edge register data_bcd, sign, ovf and ndig.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
REQ-021 Latency: with start accepted at edge k, results SHALL update at edge k+BIN_W and done SHALL be high between edges k+BIN_W and k+BIN_W+1.
REQ-022 Throughput SHALL be one conversion per BIN_W+2 cycles.
REQ-023 start SHALL be ignored in SHIFT and in DONE; there is no queuing.
REQ-024 data_bin SHALL be a don't-care except at the accepting edge.
REQ-025 On ovf=1, data_bcd SHALL saturate to all digits 9 and ndig SHALL equal DIGITS.
REQ-026 ndig SHALL be the 1-based index of the highest nonzero digit; a zero result gives ndig=1.
REQ-027 data_bcd, sign, ovf and ndig SHALL hold their last values until the next DONE-entry edge.
REQ-028 Every output digit SHALL be in the range 0..9 in every cycle.

Reset
REQ-029 Asserting Sys_RST_N=0 SHALL, asynchronously and in any state, force IDLE, busy=0, done=0, data_bcd=0, sign=0, ovf=0 and ndig=1, and clear all internal registers.
REQ-030 A conversion interrupted by reset SHALL be abandoned; no done pulse follows it.
REQ-031 After reset deasserts, the first rising edge SHALL be able to accept start.

Verification
REQ-032 Defaults, data_bin=1048575, start pulsed at edge k -> data_bcd=0x1048575, ndig=7, ovf=0, done high in cycle k+20..k+21, busy high k..k+21.
REQ-033 Defaults, data_bin=0 -> data_bcd=0x0000000, ndig=1, sign=0, ovf=0; then data_bin=9 -> 0x0000009, ndig=1.
REQ-034 DIGITS=4, BIN_W=16, data_bin=10000 -> ovf=1, data_bcd=0x9999, ndig=4; then data_bin=9999 -> ovf=0, data_bcd=0x9999.
REQ-035 SIGNED_EN=1, BIN_W=8, DIGITS=3: data_bin=0x80 -> sign=1, data_bcd=0x128; data_bin=0xFF -> sign=1, data_bcd=0x001, ndig=1; data_bin=0x7F -> sign=0, data_bcd=0x127.
REQ-036 Defaults, start held high continuously with changing data_bin -> exactly one done per 22 cycles, each result matching the operand present at its accepting edge.
REQ-037 Defaults, Sys_RST_N pulsed low mid-SHIFT (iteration 10) -> outputs at reset values immediately, no done, and a following start converts correctly.
